// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of a sync FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_wfull,
    output logic                  fifo_winc,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);
    localparam int BCW = $clog2(BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [BCW-1:0] beat_cnt, beat_nxt;

    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic             any_valid;
    logic             own_valid;
    logic             is_busy;
    logic             xfer;
    logic [WIDTH-1:0] own_data;

    // Walk from the highest offset down so the first valid after ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IDW'(k);
            if (req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        own_data  = '0;
        own_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDW'(i)) begin
                own_data  = req_data[i*WIDTH +: WIDTH];
                own_valid = req_valid[i];
            end
        end
    end

    assign is_busy = (state == BUSY);
    assign xfer    = is_busy & own_valid & ~fifo_wfull;

    always_comb begin
        req_ready = '0;
        if (is_busy) begin
            req_ready[owner] = ~fifo_wfull;
        end
    end

    assign fifo_winc  = xfer;
    assign fifo_wdata = is_busy ? own_data : '0;
    assign grant_id   = owner;
    assign busy       = is_busy;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = BUSY;
                    owner_nxt = winner;
                    beat_nxt  = '0;
                end
            end
            BUSY: begin
                if (!own_valid || (xfer && beat_cnt == BCW'(BURST - 1))) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner + 1'b1;
                    beat_nxt  = '0;
                end else if (xfer) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - vector table and scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic        wclk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wfull;
    logic        fifo_winc;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4)) dut (
        .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0] v;
        logic [7:0] d;
        logic       wf;
        logic       e_busy;
        logic [1:0] e_gid;
        logic [3:0] e_rdy;
        logic       e_winc;
        logic [7:0] e_wd;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    int idle_cnt;
    int nrun;
    logic [7:0] src [4][$];
    logic [9:0] sb [$];
    logic       wfull_v;
    logic       s_busy, s_winc;
    logic [1:0] s_gid;
    logic [3:0] s_rdy;
    logic [7:0] s_wd;
    vec_t       tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [1:0] id, input logic [7:0] d);
        sb.push_back({id, d});
    endtask

    task automatic sample();
        s_busy = busy; s_winc = fifo_winc; s_gid = grant_id; s_rdy = req_ready; s_wd = fifo_wdata;
        if (s_winc) begin
            chk("no_write_while_full", {31'b0, fifo_wfull}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_write", {22'b0, s_gid, s_wd}, 32'h3ff);
            end else begin
                chk("sb_write", {22'b0, s_gid, s_wd}, {22'b0, sb.pop_front()});
            end
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (src[i].size() > 0);
            req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
        fifo_wfull = wfull_v;
    endtask

    task automatic step();
        logic [3:0] hs;
        drive_src();
        #1;
        sample();
        if (!s_busy && |req_valid) idle_cnt++;
        hs = req_valid & req_ready;
        @(posedge wclk);
        for (int i = 0; i < 4; i++) if (hs[i]) void'(src[i].pop_front());
        @(negedge wclk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; fifo_wfull = 1'b0; wfull_v = 1'b0;
        for (int i = 0; i < 4; i++) src[i].delete();
        sb.delete();
        idle_cnt = 0;
        @(posedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
    endtask

    task automatic run_empty(input string nm, input int max, output int n);
        n = 0;
        while ((src[0].size() + src[1].size() + src[2].size() + src[3].size()) > 0 && n < max) begin
            step();
            n++;
        end
        chk({nm, "_drained"}, {31'b0, n < max}, 32'd1);
        step();
        step();
        chk({nm, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        // Burst split: six beats from requester 0 through the vector table.
        tbl[0] = '{4'b0001, 8'hA0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{4'b0001, 8'hA0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0};
        tbl[2] = '{4'b0001, 8'hA1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA1};
        tbl[3] = '{4'b0001, 8'hA2, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA2};
        tbl[4] = '{4'b0001, 8'hA3, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA3};
        tbl[5] = '{4'b0001, 8'hA4, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[6] = '{4'b0001, 8'hA4, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA4};
        tbl[7] = '{4'b0001, 8'hA5, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5};
        tbl[8] = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 8'h00};
        tbl[9] = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};

        rst_n = 1'b0;
        req_valid = 4'hF; req_data = 32'hDEADBEEF; fifo_wfull = 1'b0;
        #2;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_outputs", {17'b0, req_ready, fifo_winc, fifo_wdata, grant_id}, 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) expect_wr(2'd0, 8'hA0 + 8'(i));
        for (int k = 0; k < 10; k++) begin
            req_valid = tbl[k].v;
            req_data  = {24'h0, tbl[k].d};
            fifo_wfull = tbl[k].wf;
            #1;
            chk($sformatf("burst_v%0d_busy", k), {31'b0, busy}, {31'b0, tbl[k].e_busy});
            chk($sformatf("burst_v%0d_ready", k), {28'b0, req_ready}, {28'b0, tbl[k].e_rdy});
            chk($sformatf("burst_v%0d_winc", k), {31'b0, fifo_winc}, {31'b0, tbl[k].e_winc});
            chk($sformatf("burst_v%0d_wdata", k), {24'b0, fifo_wdata}, {24'b0, tbl[k].e_wd});
            if (tbl[k].e_busy) chk($sformatf("burst_v%0d_gid", k), {30'b0, grant_id}, {30'b0, tbl[k].e_gid});
            sample();
            @(posedge wclk);
            @(negedge wclk);
        end
        chk("burst_sb_empty", sb.size(), 32'd0);

        // Round-robin between requesters 1 and 2.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src[1].push_back(8'hB0 + 8'(i));
            src[2].push_back(8'hC0 + 8'(i));
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) expect_wr(2'd1, 8'hB0 + 8'(b*4 + i));
            for (int i = 0; i < 4; i++) expect_wr(2'd2, 8'hC0 + 8'(b*4 + i));
        end
        run_empty("rr", 60, nrun);
        chk("rr_cycles", nrun, 32'd20);
        chk("rr_idle_cycles", idle_cnt, 32'd4);

        // Pointer wrap: owner 3 releases, then 0 wins over 3.
        do_reset();
        for (int i = 0; i < 6; i++) src[3].push_back(8'hD0 + 8'(i));
        for (int i = 0; i < 4; i++) expect_wr(2'd3, 8'hD0 + 8'(i));
        expect_wr(2'd0, 8'hE0); expect_wr(2'd0, 8'hE1);
        expect_wr(2'd3, 8'hD4); expect_wr(2'd3, 8'hD5);
        step(); step();
        src[0].push_back(8'hE0); src[0].push_back(8'hE1);
        run_empty("wrap", 40, nrun);

        // Full stall during beat 2 of requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src[0].push_back(8'hF0 + 8'(i));
            expect_wr(2'd0, 8'hF0 + 8'(i));
        end
        for (int c = 0; c < 9; c++) begin
            wfull_v = (c >= 3 && c <= 5);
            step();
            if (c >= 3 && c <= 5) begin
                chk($sformatf("stall_c%0d_ready", c), {28'b0, s_rdy}, 32'd0);
                chk($sformatf("stall_c%0d_winc", c), {31'b0, s_winc}, 32'd0);
                chk($sformatf("stall_c%0d_busy", c), {31'b0, s_busy}, 32'd1);
            end
            if (c == 6) chk("stall_resume_wdata", {31'b0, s_winc, s_wd}, {23'b0, 1'b1, 8'hF2});
            if (c == 8) chk("stall_release", {31'b0, s_busy}, 32'd0);
        end
        wfull_v = 1'b0;
        chk("stall_sb_empty", sb.size(), 32'd0);

        // Early drop: requester 2 stops after one beat while 1 waits.
        do_reset();
        src[1].push_back(8'h11);
        expect_wr(2'd1, 8'h11);
        step(); step(); step();
        src[2].push_back(8'h20);
        src[1].push_back(8'h12); src[1].push_back(8'h13);
        expect_wr(2'd2, 8'h20); expect_wr(2'd1, 8'h12); expect_wr(2'd1, 8'h13);
        step();
        chk("drop_arb_idle", {31'b0, s_busy}, 32'd0);
        step();
        step();
        chk("drop_release_cycle", {29'b0, s_busy, s_gid}, {29'b0, 1'b1, 2'd2});
        chk("drop_no_write", {31'b0, s_winc}, 32'd0);
        step();
        chk("drop_idle", {31'b0, s_busy}, 32'd0);
        step();
        chk("drop_grant1", {28'b0, s_busy, s_gid, s_winc}, {28'b0, 1'b1, 2'd1, 1'b1});
        run_empty("drop", 20, nrun);

        // Asynchronous reset between edges during beat 1.
        do_reset();
        for (int i = 0; i < 6; i++) src[0].push_back(8'h50 + 8'(i));
        for (int i = 0; i < 6; i++) if (i != 1 || 1) expect_wr(2'd0, 8'h50 + 8'(i));
        step(); step();
        drive_src();
        #1;
        chk("areset_pre_winc", {31'b0, fifo_winc}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("areset_outputs", {17'b0, busy, req_ready, fifo_winc, fifo_wdata, grant_id}, 32'd0);
        @(posedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
        step();
        chk("areset_idle", {31'b0, s_busy}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        step();
        chk("areset_fresh_count", {31'b0, s_busy}, 32'd0);
        run_empty("areset", 20, nrun);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
